// File: rtl/rng_seed_gen.sv
// rng_seed_gen: seed source for the RNG LFSR.
// Samples a raw entropy bit every SAMPLE_DIV clocks, removes bias with a von
// Neumann corrector and shifts the surviving bits MSB-first into a seed word.
// The word is offered on a valid/ready port. A repetition-count health test
// on the raw samples blocks delivery when the source is stuck.
module rng_seed_gen #(
  parameter int SEED_WIDTH = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  ent_i,
  output logic                  seed_valid_o,
  input  logic                  seed_ready_i,
  output logic [SEED_WIDTH-1:0] seed_o,
  output logic                  health_err_o,
  input  logic                  err_clr_i
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int CNT_W = $clog2(SEED_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEED_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  // Next repetition count: restart at 1 on a new value, saturate at REP_LIMIT.
  function automatic logic [REP_W-1:0] rep_step(input logic [REP_W-1:0] rep,
                                                input logic             same);
    logic [REP_W-1:0] r;
    if (!same) begin
      r = REP_ONE;
    end else if (rep == REP_MAX) begin
      r = rep;
    end else begin
      r = rep + REP_ONE;
    end
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  phase_q, phase_d;
  logic                  a_q, a_d;
  logic                  prev_q, prev_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEED_WIDTH-1:0] seed_q, seed_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [REP_W-1:0]      rep_nxt_s;
  logic                  clr_run_s;

  // Next-state logic: FSM, sample divider, corrector, packer and health test.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    a_d       = a_q;
    prev_d    = prev_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    valid_d   = valid_q;
    err_d     = err_q;
    rep_nxt_s = rep_step(rep_q, ent_i == prev_q);
    clr_run_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_run_s = 1'b1;
        valid_d   = 1'b0;
        if (en_i) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (!en_i) begin
          // Abandon the partial seed; seed_o keeps whatever it holds.
          state_d   = ST_IDLE;
          clr_run_s = 1'b1;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rep_nxt_s == REP_MAX) begin
            // Health trip outranks a seed completing on the same strobe.
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            valid_d   = 1'b0;
            clr_run_s = 1'b1;
          end else begin
            rep_d  = rep_nxt_s;
            prev_d = ent_i;
            if (!phase_q) begin
              a_d     = ent_i;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (ent_i != a_q) begin
                seed_d = {seed_q[SEED_WIDTH-2:0], a_q};
                if (cnt_q == CNT_LAST) begin
                  state_d   = ST_HOLD;
                  valid_d   = 1'b1;
                  clr_run_s = 1'b1;
                end else begin
                  cnt_d = cnt_q + CNT_ONE;
                end
              end else begin
                // Equal pair carries no unbiased bit.
                seed_d = seed_q;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_HOLD: begin
        clr_run_s = 1'b1;
        if (valid_q && seed_ready_i) begin
          valid_d = 1'b0;
          if (en_i) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end

      ST_ERROR: begin
        clr_run_s = 1'b1;
        valid_d   = 1'b0;
        if (err_clr_i) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clr_run_s = 1'b1;
        valid_d   = 1'b0;
      end
    endcase

    // Collection bookkeeping only lives inside COLLECT.
    if (clr_run_s) begin
      div_d   = '0;
      phase_d = 1'b0;
      a_d     = 1'b0;
      prev_d  = 1'b0;
      rep_d   = '0;
      cnt_d   = '0;
    end else begin
      rep_d = rep_d;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      a_q     <= 1'b0;
      prev_q  <= 1'b0;
      rep_q   <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      a_q     <= a_d;
      prev_q  <= prev_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign seed_o       = seed_q;
  assign seed_valid_o = valid_q;
  assign health_err_o = err_q;

endmodule

// File: tb/tb_rng_seed_gen.sv
// Directed self-checking bench for rng_seed_gen: default instance for the
// main flows and a SAMPLE_DIV=1 / REP_LIMIT=2 / 8-bit instance for the
// fast health-trip cases.
module tb_rng_seed_gen;

  logic        clk;
  logic        rst, en, ent, ready, clr;
  logic        valid, herr;
  logic [31:0] seed;
  logic        rst2, en2, ent2, ready2, clr2;
  logic        valid2, herr2;
  logic [7:0]  seed2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int t0      = 0;

  rng_seed_gen dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ent_i(ent),
    .seed_valid_o(valid), .seed_ready_i(ready), .seed_o(seed),
    .health_err_o(herr), .err_clr_i(clr)
  );

  rng_seed_gen #(.SEED_WIDTH(8), .SAMPLE_DIV(1), .REP_LIMIT(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .ent_i(ent2),
    .seed_valid_o(valid2), .seed_ready_i(ready2), .seed_o(seed2),
    .health_err_o(herr2), .err_clr_i(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One emitted bit b on the default instance: raw pair {b, ~b}, 4 clocks each.
  task automatic send_bit(input logic b);
    ent = b;
    tick(4);
    ent = ~b;
    tick(4);
  endtask

  // Emit the top nbits of w, MSB first.
  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[31-i]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ent = 1'b0; ready = 1'b0; clr = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; ent2 = 1'b0; ready2 = 1'b0; clr2 = 1'b0;
    tick(2);
    check("rst_seed", seed, 32'h0000_0000);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_herr", {31'd0, herr}, 32'd0);
    check("rst2_seed", {24'd0, seed2}, 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    tick(1);

    // 1: pairs "10" x32 -> all ones, valid 257 clocks after enable
    en = 1'b1;
    t0 = cyc;
    tick(1);
    send_word(32'hFFFF_FFFF, 31);
    ent = 1'b1;
    tick(4);
    check("t1_no_valid_early", {31'd0, valid}, 32'd0);
    ent = 1'b0;
    tick(4);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_seed", seed, 32'hFFFF_FFFF);
    check("t1_latency", cyc - t0, 32'd257);

    // accept, new collection starts immediately
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t1_accept_drop", {31'd0, valid}, 32'd0);

    // 2: alternating bits with discarded "11"/"00" pairs interleaved
    t0 = cyc;
    for (int i = 0; i < 32; i++) begin
      if (i == 8 || i == 16 || i == 24 || i == 31) begin
        ent = i[3];
        tick(4);
        tick(4);
      end
      ent = ~i[0];
      tick(4);
      if (i == 31) begin
        check("t2_no_valid_early", {31'd0, valid}, 32'd0);
      end
      ent = i[0];
      tick(4);
    end
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_seed", seed, 32'hAAAA_AAAA);
    check("t2_latency", cyc - t0, 32'd288);

    // 3: hold without ready, entropy toggling, en_i dropped half way
    for (int i = 0; i < 100; i++) begin
      ent = i[0];
      en  = (i < 50);
      tick(1);
      check("t3_hold_valid", {31'd0, valid}, 32'd1);
      check("t3_hold_seed", seed, 32'hAAAA_AAAA);
    end
    en = 1'b1;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t3_accept_drop", {31'd0, valid}, 32'd0);

    // 5: ten ones shifted in, then disable: partial kept on seed_o, discarded internally
    send_word(32'hFFC0_0000, 10);
    check("t5_partial_seed", seed, 32'hAAAA_ABFF);
    check("t5_partial_valid", {31'd0, valid}, 32'd0);
    en = 1'b0;
    tick(1);
    ent = 1'b1;
    tick(3);
    ent = 1'b0;
    tick(3);
    check("t5_idle_seed_kept", seed, 32'hAAAA_ABFF);
    en = 1'b1;
    tick(1);
    send_word(32'h1234_5678, 31);
    check("t5_31bits_no_valid", {31'd0, valid}, 32'd0);
    send_bit(1'b0);
    check("t5_valid", {31'd0, valid}, 32'd1);
    check("t5_seed", seed, 32'h1234_5678);

    // reset while holding a seed
    rst = 1'b1;
    tick(1);
    check("t5_rst_seed", seed, 32'h0000_0000);
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    check("t5_rst_herr", {31'd0, herr}, 32'd0);
    rst = 1'b0;
    en = 1'b0;
    tick(1);

    // 4: stuck-at-1 source trips on the 32nd strobe
    en = 1'b1;
    ent = 1'b1;
    tick(1);
    tick(4 * 31);
    check("t4_herr_before", {31'd0, herr}, 32'd0);
    tick(4);
    check("t4_herr_trip", {31'd0, herr}, 32'd1);
    check("t4_valid_low", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      ent = i[1];
      tick(1);
    end
    check("t4_herr_sticky", {31'd0, herr}, 32'd1);
    check("t4_valid_sticky", {31'd0, valid}, 32'd0);
    clr = 1'b1;
    en = 1'b0;
    tick(1);
    clr = 1'b0;
    check("t4_herr_cleared", {31'd0, herr}, 32'd0);
    en = 1'b1;
    tick(1);
    send_word(32'hC3A5_0F96, 32);
    check("t4_recover_valid", {31'd0, valid}, 32'd1);
    check("t4_recover_seed", seed, 32'hC3A5_0F96);
    check("t4_recover_herr", {31'd0, herr}, 32'd0);
    en = 1'b0;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;

    // 6: SAMPLE_DIV=1, REP_LIMIT=2 -> trip on the second equal sample
    en2 = 1'b1;
    tick(1);
    ent2 = 1'b1;
    tick(1);
    check("t6_herr_first", {31'd0, herr2}, 32'd0);
    tick(1);
    check("t6_herr_second", {31'd0, herr2}, 32'd1);
    check("t6_valid_trip", {31'd0, valid2}, 32'd0);
    clr2 = 1'b1;
    en2 = 1'b0;
    tick(1);
    clr2 = 1'b0;
    check("t6_herr_cleared", {31'd0, herr2}, 32'd0);
    en2 = 1'b1;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      ent2 = 1'b1;
      tick(1);
      ent2 = 1'b0;
      tick(1);
    end
    check("t6_seven_bits", {24'd0, seed2}, 32'h0000_007F);
    check("t6_seven_no_valid", {31'd0, valid2}, 32'd0);
    // the pair that would carry the last bit repeats instead and trips
    ent2 = 1'b1;
    tick(1);
    tick(1);
    check("t6_final_trip_herr", {31'd0, herr2}, 32'd1);
    check("t6_final_trip_valid", {31'd0, valid2}, 32'd0);
    clr2 = 1'b1;
    en2 = 1'b0;
    tick(1);
    clr2 = 1'b0;
    en2 = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      ent2 = 1'b1;
      tick(1);
      ent2 = 1'b0;
      tick(1);
    end
    check("t6_full_valid", {31'd0, valid2}, 32'd1);
    check("t6_full_seed", {24'd0, seed2}, 32'h0000_00FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
